// File: rtl/serial_paralelo_rx_pkg.sv
// Shared line-code symbols and receiver state encoding for the serial-to-parallel receiver.
// The symbol values must match the byte-to-serial transmitter.
package serial_paralelo_rx_pkg;

  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] IDL = 8'h7C;

  typedef enum logic [1:0] {
    StSearch = 2'b00,
    StAlign  = 2'b01,
    StSync   = 2'b10
  } rx_state_e;

  // Payload bytes are everything the transmitter does not use for alignment or filler.
  function automatic logic is_payload(input logic [7:0] sym);
    return (sym != COM) && (sym != IDL);
  endfunction

endpackage

// File: rtl/serial_paralelo_rx_if.sv
// Serial-in / byte-out bundle of the receiver; clock and reset stay outside.
// master: the serial source and consumer side, slave: the receiver.
interface serial_paralelo_rx_if;

  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  active
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output active
  );

endinterface

// File: rtl/serial_paralelo_rx_shift.sv
// Serial history register: presents the 8-bit window that includes the bit sampled this edge.
// Only the seven older bits need storage; the newest bit comes straight from the line.
module serial_paralelo_rx_shift (
  input  logic       dclk,
  input  logic       reset,
  input  logic       i_bit,
  output logic [7:0] o_nsr
);

  logic [6:0] r_hist;

  assign o_nsr = {r_hist, i_bit};

  always_ff @(posedge dclk or posedge reset) begin
    if (reset) begin
      r_hist <= '0;
    end else begin
      r_hist <= o_nsr[6:0];
    end
  end

endmodule

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver: locks byte alignment on repeated COM symbols, then strobes
// every non-COM, non-IDL byte out on its 8th bit edge. Only reset leaves SYNC.
module serial_paralelo_rx
  import serial_paralelo_rx_pkg::*;
#(
  parameter int unsigned COM_THRESH = 4  // valid range 1..15
) (
  input  logic                 dclk,
  input  logic                 reset,
  serial_paralelo_rx_if.slave  bus
);

  localparam logic [3:0] ComThr = 4'(COM_THRESH);

  rx_state_e  r_state,   w_state_nxt;
  logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [3:0] r_com_cnt, w_com_cnt_nxt;
  logic [7:0] r_data,    w_data_nxt;
  logic       r_valid,   w_valid_nxt;
  logic       r_active,  w_active_nxt;

  logic [7:0] w_nsr;
  logic       w_is_com;
  logic       w_boundary;
  logic [3:0] w_com_inc;

  serial_paralelo_rx_shift u_shift (
    .dclk  (dclk),
    .reset (reset),
    .i_bit (bus.data_in),
    .o_nsr (w_nsr)
  );

  assign w_is_com   = (w_nsr == COM);
  assign w_boundary = (r_bit_cnt == 3'd7);
  assign w_com_inc  = r_com_cnt + 4'd1;

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_com_cnt_nxt = r_com_cnt;
    w_data_nxt    = r_data;
    w_valid_nxt   = 1'b0;
    w_active_nxt  = r_active;

    unique case (r_state)
      StSearch: begin
        // Bit-level sliding search; the COM just seen fixes the byte boundary.
        if (w_is_com) begin
          w_state_nxt   = StAlign;
          w_bit_cnt_nxt = 3'd0;
          w_com_cnt_nxt = 4'd1;
        end
      end

      StAlign: begin
        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
        if (w_boundary) begin
          if (w_is_com) begin
            if (w_com_inc >= ComThr) begin
              w_com_cnt_nxt = ComThr;
              w_state_nxt   = StSync;
              w_active_nxt  = 1'b1;
            end else begin
              w_com_cnt_nxt = w_com_inc;
            end
          end else begin
            w_com_cnt_nxt = 4'd0;
            w_state_nxt   = StSearch;
          end
        end
      end

      StSync: begin
        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
        if (w_boundary && is_payload(w_nsr)) begin
          w_data_nxt  = w_nsr;
          w_valid_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt   = StSearch;
        w_bit_cnt_nxt = 3'd0;
        w_com_cnt_nxt = 4'd0;
        w_active_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge dclk or posedge reset) begin
    if (reset) begin
      r_state   <= StSearch;
      r_bit_cnt <= 3'd0;
      r_com_cnt <= 4'd0;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_active  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_com_cnt <= w_com_cnt_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_active  <= w_active_nxt;
    end
  end

  assign bus.data_out  = r_data;
  assign bus.valid_out = r_valid;
  assign bus.active    = r_active;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Bench for serial_paralelo_rx: directed link scenarios plus random byte/slip traffic, each
// dclk edge compared against a position-based reference model for thresholds 4 and 2.
module tb_serial_paralelo_rx;
  import serial_paralelo_rx_pkg::*;

  logic dclk = 1'b0;
  logic reset;
  logic data_in;

  always #5 dclk = ~dclk;

  serial_paralelo_rx_if rx4_if ();
  serial_paralelo_rx_if rx2_if ();

  assign rx4_if.data_in = data_in;
  assign rx2_if.data_in = data_in;

  serial_paralelo_rx #(.COM_THRESH(4)) u_dut4 (
    .dclk  (dclk),
    .reset (reset),
    .bus   (rx4_if.slave)
  );

  serial_paralelo_rx #(.COM_THRESH(2)) u_dut2 (
    .dclk  (dclk),
    .reset (reset),
    .bus   (rx2_if.slave)
  );

  // Reference model: alignment tracked as the bit index of the locking COM; boundaries are
  // every 8th bit after it.
  typedef struct {
    logic [7:0] win;
    int         n;
    int         phase;   // 0 searching, 1 counting COMs, 2 locked
    int         anchor;
    int         ncom;
    logic       valid;
    logic       active;
    logic [7:0] data;
  } mdl_t;

  mdl_t m4, m2;
  int   n_err = 0;
  int   n_chk = 0;
  int   edge_n = 0;
  int   strobes4 = 0;
  int   strobes2 = 0;
  int   last4 = -1;
  int   gap4 = 0;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.win = 8'h00; m.n = 0; m.phase = 0; m.anchor = 0; m.ncom = 0;
    m.valid = 1'b0; m.active = 1'b0; m.data = 8'h00;
    return m;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m_in, input logic b, input int th);
    mdl_t m = m_in;
    m.win   = {m.win[6:0], b};
    m.n     = m.n + 1;
    m.valid = 1'b0;
    if (m.phase == 0) begin
      if (m.win == COM) begin
        m.phase = 1; m.anchor = m.n; m.ncom = 1;
      end
    end else if ((m.n - m.anchor) % 8 == 0) begin
      if (m.phase == 1) begin
        if (m.win == COM) begin
          m.ncom = (m.ncom + 1 > th) ? th : m.ncom + 1;
          if (m.ncom >= th) begin
            m.phase = 2; m.active = 1'b1;
          end
        end else begin
          m.phase = 0; m.ncom = 0;
        end
      end else if (m.win != COM && m.win != IDL) begin
        m.data = m.win; m.valid = 1'b1;
      end
    end
    return m;
  endfunction

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, "_act4"}, 8'(rx4_if.active),    8'(m4.active));
    check_val({tag, "_val4"}, 8'(rx4_if.valid_out), 8'(m4.valid));
    check_val({tag, "_dat4"}, rx4_if.data_out,      m4.data);
    check_val({tag, "_act2"}, 8'(rx2_if.active),    8'(m2.active));
    check_val({tag, "_val2"}, 8'(rx2_if.valid_out), 8'(m2.valid));
    check_val({tag, "_dat2"}, rx2_if.data_out,      m2.data);
  endtask

  task automatic send_bit(input logic b);
    @(negedge dclk);
    data_in = b;
    @(posedge dclk);
    m4 = mdl_step(m4, b, 4);
    m2 = mdl_step(m2, b, 2);
    edge_n++;
    #1;
    check_outputs("bit");
    if (rx4_if.valid_out === 1'b1) begin
      if (last4 >= 0) gap4 = edge_n - last4;
      last4 = edge_n;
      strobes4++;
    end
    if (rx2_if.valid_out === 1'b1) strobes2++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  // Reset held for 3 edges with data_in toggling; released just after an edge so the next
  // edge that shifts data is always one the model sees.
  task automatic apply_reset();
    @(negedge dclk);
    reset = 1'b1;
    m4 = mdl_reset();
    m2 = mdl_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge dclk);
      data_in = ~data_in;
      @(posedge dclk);
      #1;
      check_outputs("rst");
    end
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [34:0] lock_bits;
    logic [7:0]  data_seq [5];
    logic [7:0]  broken_seq [7];

    reset   = 1'b1;
    data_in = 1'b0;
    m4 = mdl_reset();
    m2 = mdl_reset();
    #1;
    check_outputs("por");
    apply_reset();

    // Lock: 3 garbage bits then four COMs; active must rise on bit edge 35 exactly.
    lock_bits = {3'($urandom), COM, COM, COM, COM};
    for (int i = 34; i >= 0; i--) begin
      send_bit(lock_bits[i]);
      if (i == 1) check_val("lock_pre35", 8'(rx4_if.active), 8'h00);
      if (i == 0) check_val("lock_at35", 8'(rx4_if.active), 8'h01);
    end
    check_val("lock_nostrobe", 8'(strobes4), 8'h00);

    // Data after lock: only A5 and FF are forwarded, 8 edges apart.
    data_seq = '{COM, IDL, 8'hA5, 8'hFF, COM};
    last4 = -1;
    gap4 = 0;
    strobes4 = 0;
    foreach (data_seq[j]) send_byte(data_seq[j]);
    check_val("data_strobes", 8'(strobes4), 8'h02);
    check_val("data_gap", 8'(gap4), 8'h08);
    check_val("data_hold", rx4_if.data_out, 8'hFF);

    // Broken lock: the 3C byte aborts alignment; the last four COMs lock again.
    apply_reset();
    broken_seq = '{COM, COM, 8'h3C, COM, COM, COM, COM};
    foreach (broken_seq[j]) begin
      send_byte(broken_seq[j]);
      if (j == 5) check_val("broken_pre", 8'(rx4_if.active), 8'h00);
      if (j == 6) check_val("broken_lock", 8'(rx4_if.active), 8'h01);
    end

    // Async reset between edges while valid_out is high.
    send_byte(8'hA5);
    check_val("prerst_valid", 8'(rx4_if.valid_out), 8'h01);
    #2 reset = 1'b1;
    #1;
    check_val("arst_act4", 8'(rx4_if.active), 8'h00);
    check_val("arst_val4", 8'(rx4_if.valid_out), 8'h00);
    check_val("arst_dat4", rx4_if.data_out, 8'h00);
    check_val("arst_act2", 8'(rx2_if.active), 8'h00);
    m4 = mdl_reset();
    m2 = mdl_reset();
    @(posedge dclk);
    #1 reset = 1'b0;
    for (int j = 0; j < 4; j++) begin
      send_byte(COM);
      if (j == 2) check_val("relock_pre", 8'(rx4_if.active), 8'h00);
      if (j == 3) check_val("relock", 8'(rx4_if.active), 8'h01);
    end

    // Threshold of 2: active after the second COM, then one strobe of 55.
    apply_reset();
    strobes2 = 0;
    send_byte(COM);
    check_val("th2_pre", 8'(rx2_if.active), 8'h00);
    send_byte(COM);
    check_val("th2_lock", 8'(rx2_if.active), 8'h01);
    send_byte(8'h55);
    check_val("th2_strobes", 8'(strobes2), 8'h01);
    check_val("th2_data", rx2_if.data_out, 8'h55);

    // Random traffic: COM bursts, idles, payload, bit slips and occasional resets.
    for (int it = 0; it < 80; it++) begin
      int unsigned r;
      r = $urandom_range(0, 11);
      if (r == 0) begin
        apply_reset();
      end else if (r <= 4) begin
        int unsigned k;
        k = $urandom_range(1, 6);
        for (int j = 0; j < int'(k); j++) send_byte(COM);
      end else if (r == 5) begin
        send_byte(IDL);
      end else if (r == 6) begin
        int unsigned k;
        k = $urandom_range(1, 7);
        for (int j = 0; j < int'(k); j++) send_bit(1'($urandom));
      end else begin
        send_byte(8'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
